// File: rtl/ser_word_collector_pkg.sv
// Shared definitions for the serial word collector: FSM state encoding and
// default widths, reused by the upstream FSM bench and the display stage.
package ser_word_collector_pkg;

   localparam int DEF_DATA_W = 8;   // word width in bits
   localparam int DEF_LEN_W  = 4;   // must be able to hold DEF_DATA_W
   localparam int DEF_FCNT_W = 8;   // frame counter width

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,   // waiting for the first payload bit of a frame
      ST_COLLECT = 2'd1,   // shifting in bits of a partial word
      ST_PENDING = 2'd2    // full word held, not yet known whether it is last
   } state_t;

endpackage

// File: rtl/ser_word_collector_out_hold_reg.sv
// Single-entry valid/ready holding register. A load is accepted when the
// entry is empty or is being taken on the same edge; otherwise the incoming
// word is dropped and a sticky overflow flag is raised.
module ser_word_collector_out_hold_reg #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic [LEN_W-1:0]  i_len,
   input  logic              i_last,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [LEN_W-1:0]  o_len,
   output logic              o_last,
   output logic              o_overflow
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [LEN_W-1:0]  r_len;
   logic              r_last;
   logic              r_overflow;

   logic w_take;
   logic w_accept;

   // The entry frees up on the same edge it is taken, so back-to-back words
   // transfer without a bubble.
   assign w_take   = r_valid & i_ready;
   assign w_accept = i_load & (~r_valid | w_take);

   // Entry update: load on accept, clear on take, flag a drop on a full entry.
   always_ff @(posedge clk) begin
      // NOTE: state is assigned with <= so every register samples pre-edge
      // values; blocking assignments here would create ordering races.
      if (rst) begin
         // NOTE: the payload fields are reset too, because the port contract
         // requires all outputs to read zero after reset, not just o_valid.
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_len      <= '0;
         r_last     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_len   <= i_len;
            r_last  <= i_last;
         end else if (w_take) begin
            r_valid <= 1'b0;
         end
         if (i_load && !w_accept) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_len      = r_len;
   assign o_last     = r_last;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/ser_word_collector.sv
// Serial payload collector: packs serIn bits MSB-first into DATA_W-bit words
// with a length field and last-of-frame marker, and hands them to a
// valid/ready consumer through a single-entry holding register.
module ser_word_collector
   import ser_word_collector_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int FCNT_W = DEF_FCNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Clk_EN,
   input  logic              serIn,
   input  logic              serInValid,
   output logic [DATA_W-1:0] parData,
   output logic [LEN_W-1:0]  parLen,
   output logic              parLast,
   output logic              parValid,
   input  logic              parReady,
   output logic [FCNT_W-1:0] frameCnt,
   output logic              overflow
);

   state_t            r_state;
   logic [DATA_W-1:0] r_shreg;
   logic [LEN_W-1:0]  r_bit_cnt;
   logic [FCNT_W-1:0] r_frame_cnt;

   logic              w_emit;
   logic              w_emit_last;

   // A word is released when a frame ends, or when a full pending word is
   // followed by another bit (so it cannot be the last one).
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      w_emit      = 1'b0;
      w_emit_last = 1'b0;
      if (Clk_EN) begin
         case (r_state)
            ST_COLLECT: begin
               if (!serInValid) begin
                  w_emit      = 1'b1;
                  w_emit_last = 1'b1;
               end
            end
            ST_PENDING: begin
               w_emit      = 1'b1;
               w_emit_last = ~serInValid;
            end
            default: ;
         endcase
      end
   end

   // Serial-side FSM, shift register and counters; advances only on enabled
   // samples. A new word always starts from zero so bits above parLen are 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_frame_cnt <= '0;
      end else if (Clk_EN) begin
         case (r_state)
            ST_IDLE: begin
               if (serInValid) begin
                  r_shreg   <= {{(DATA_W-1){1'b0}}, serIn};
                  r_bit_cnt <= LEN_W'(1);
                  r_state   <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (serInValid) begin
                  r_shreg   <= {r_shreg[DATA_W-2:0], serIn};
                  r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                  if (r_bit_cnt == LEN_W'(DATA_W - 1)) begin
                     r_state <= ST_PENDING;
                  end
               end else begin
                  r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                  r_shreg     <= '0;
                  r_bit_cnt   <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            ST_PENDING: begin
               if (serInValid) begin
                  r_shreg   <= {{(DATA_W-1){1'b0}}, serIn};
                  r_bit_cnt <= LEN_W'(1);
                  r_state   <= ST_COLLECT;
               end else begin
                  r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                  r_shreg     <= '0;
                  r_bit_cnt   <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   ser_word_collector_out_hold_reg #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_out_hold_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_emit),
      .i_data     (r_shreg),
      .i_len      (r_bit_cnt),
      .i_last     (w_emit_last),
      .i_ready    (parReady),
      .o_valid    (parValid),
      .o_data     (parData),
      .o_len      (parLen),
      .o_last     (parLast),
      .o_overflow (overflow)
   );

   assign frameCnt = r_frame_cnt;

endmodule

// File: tb/tb_ser_word_collector.sv
// Self-checking bench for ser_word_collector: directed scenarios with fixed
// expected words, then randomized traffic against a frame-level model.
module tb_ser_word_collector;

   localparam int DW = 8;
   localparam int LW = 4;
   localparam int FW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          Clk_EN = 1'b0;
   logic          serIn = 1'b0;
   logic          serInValid = 1'b0;
   logic [DW-1:0] parData;
   logic [LW-1:0] parLen;
   logic          parLast;
   logic          parValid;
   logic          parReady = 1'b0;
   logic [FW-1:0] frameCnt;
   logic          overflow;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: bits of the word under construction, plus the
   // consumer-visible holding entry.
   bit            m_cur[$];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [LW-1:0] m_len;
   logic          m_last;
   logic          m_ovf;
   logic [FW-1:0] m_fcnt;

   ser_word_collector #(.DATA_W(DW), .LEN_W(LW), .FCNT_W(FW)) dut (
      .clk        (clk),
      .rst        (rst),
      .Clk_EN     (Clk_EN),
      .serIn      (serIn),
      .serInValid (serInValid),
      .parData    (parData),
      .parLen     (parLen),
      .parLast    (parLast),
      .parValid   (parValid),
      .parReady   (parReady),
      .frameCnt   (frameCnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Word value of a bit list, first bit most significant.
   function automatic logic [DW-1:0] pack(input bit q[$]);
      logic [DW-1:0] v = '0;
      foreach (q[i]) v = {v[DW-2:0], logic'(q[i])};
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_edge();
      bit   e_bits[$];
      logic have_emit = 1'b0;
      logic e_last = 1'b0;
      logic take;
      if (rst) begin
         m_cur.delete();
         m_valid = 1'b0; m_data = '0; m_len = '0; m_last = 1'b0;
         m_ovf = 1'b0; m_fcnt = '0;
         return;
      end
      take = m_valid & parReady;
      if (Clk_EN) begin
         if (serInValid) begin
            if (m_cur.size() == DW) begin
               have_emit = 1'b1; e_bits = m_cur; e_last = 1'b0;
               m_cur.delete();
            end
            m_cur.push_back(serIn);
         end else if (m_cur.size() > 0) begin
            have_emit = 1'b1; e_bits = m_cur; e_last = 1'b1;
            m_cur.delete();
            m_fcnt = m_fcnt + 1'b1;
         end
      end
      if (have_emit) begin
         if (!m_valid || take) begin
            m_valid = 1'b1;
            m_data  = pack(e_bits);
            m_len   = LW'(e_bits.size());
            m_last  = e_last;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (take) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all();
      check("valid", 32'(parValid), 32'(m_valid));
      check("frame_cnt", 32'(frameCnt), 32'(m_fcnt));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_valid) begin
         check("data", 32'(parData), 32'(m_data));
         check("len", 32'(parLen), 32'(m_len));
         check("last", 32'(parLast), 32'(m_last));
      end
   endtask

   // Apply one clock cycle of inputs, update the model, check 1 ns later.
   task automatic drive(input logic r, input logic en, input logic v,
                        input logic b, input logic rdy);
      rst = r; Clk_EN = en; serInValid = v; serIn = b; parReady = rdy;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 32'(parValid), 32'd0);
      check({tag, "_data"}, 32'(parData), 32'd0);
      check({tag, "_len"}, 32'(parLen), 32'd0);
      check({tag, "_last"}, 32'(parLast), 32'd0);
      check({tag, "_fcnt"}, 32'(frameCnt), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
   endtask

   task automatic send_bits(input logic [DW-1:0] bits, input int n, input logic rdy);
      for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, 1'b1, bits[i], rdy);
   endtask

   initial begin
      bit   en_bits[$];
      logic rv = 1'b0;
      logic en;

      // Reset state.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_reset_state("reset");

      // Full 8-bit frame ending on a low-valid sample.
      send_bits(8'hB2, 8, 1'b0);
      check("t1_pre_valid", 32'(parValid), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t1_data", 32'(parData), 32'hB2);
      check("t1_len", 32'(parLen), 32'd8);
      check("t1_last", 32'(parLast), 32'd1);
      check("t1_valid", 32'(parValid), 32'd1);
      check("t1_fcnt", 32'(frameCnt), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t1_taken", 32'(parValid), 32'd0);

      // Short 3-bit frame.
      send_bits(8'h05, 3, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t2_data", 32'(parData), 32'h05);
      check("t2_len", 32'(parLen), 32'd3);
      check("t2_last", 32'(parLast), 32'd1);
      check("t2_fcnt", 32'(frameCnt), 32'd2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

      // Two-word frame: 0xA5 then 1,1.
      send_bits(8'hA5, 8, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check("t3_w0_data", 32'(parData), 32'hA5);
      check("t3_w0_len", 32'(parLen), 32'd8);
      check("t3_w0_last", 32'(parLast), 32'd0);
      check("t3_w0_valid", 32'(parValid), 32'd1);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check("t3_w0_taken", 32'(parValid), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t3_w1_data", 32'(parData), 32'h03);
      check("t3_w1_len", 32'(parLen), 32'd2);
      check("t3_w1_last", 32'(parLast), 32'd1);
      check("t3_fcnt", 32'(frameCnt), 32'd3);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

      // Overflow: consumer stalled across two frames.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits(8'h07, 3, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(8'h02, 3, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t4_data", 32'(parData), 32'h07);
      check("t4_len", 32'(parLen), 32'd3);
      check("t4_ovf", 32'(overflow), 32'd1);
      check("t4_fcnt", 32'(frameCnt), 32'd2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t4_taken", 32'(parValid), 32'd0);
      check("t4_ovf_sticky", 32'(overflow), 32'd1);

      // Sparse enable: only one clock in four samples the serial input.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 32; k++) begin
         logic b = 1'($urandom_range(0, 1));
         en = (k % 4 == 0);
         if (en) en_bits.push_back(b);
         drive(1'b0, en, 1'b1, b, 1'b1);
      end
      check("t5_pending_valid", 32'(parValid), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t5_data", 32'(parData), 32'(pack(en_bits)));
      check("t5_len", 32'(parLen), 32'd8);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a frame.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits(8'h0D, 4, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check_reset_state("t6_rst");
      send_bits(8'h03, 2, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t6_data", 32'(parData), 32'h03);
      check("t6_len", 32'(parLen), 32'd2);
      check("t6_last", 32'(parLast), 32'd1);
      check("t6_fcnt", 32'(frameCnt), 32'd1);

      // Randomized traffic: variable frame lengths, gaps, stalls, resets.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 5) == 0) rv = ~rv;
         drive(1'($urandom_range(0, 499) == 0),
               1'($urandom_range(0, 3) != 0),
               rv,
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
